// File: rtl/soft_depuncture_if.sv
// Soft depuncture stream interface: de-interleaved soft symbols in,
// paired X/Y soft values out. The source side uses master, the
// depuncturer uses slave.
interface soft_depuncture_if;
  logic       isop;
  logic       ival;
  logic       ieop;
  logic [4:0] idat;
  logic       osop;
  logic       oval;
  logic       oeop;
  logic [4:0] odat0;
  logic [4:0] odat1;
  logic       oerr;

  modport master (
    output isop, ival, ieop, idat,
    input  osop, oval, oeop, odat0, odat1, oerr
  );

  modport slave (
    input  isop, ival, ieop, idat,
    output osop, oval, oeop, odat0, odat1, oerr
  );
endinterface

// File: rtl/soft_depuncture.sv
// Rate-3/4 soft depuncturer. Received order per group of four symbols is
// X1 Y1 Y2 X3 (pattern X=101, Y=110); each group yields three (X, Y)
// beats with the punctured positions filled by ERASE_VAL. Block framing
// is checked against BLK_LEN and violations raise a one-cycle oerr.
module soft_depuncture #(
  parameter int         BLK_LEN   = 1920,
  parameter logic [4:0] ERASE_VAL = 5'd0
) (
  input logic               iclk,
  input logic               irst,
  soft_depuncture_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(BLK_LEN);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BLK_LEN - 1);
  localparam logic [CNT_W-1:0]   ONE_CNT  = CNT_W'(1);
  localparam logic [0:0]         ST_IDLE  = 1'b0;
  localparam logic [0:0]         ST_RUN   = 1'b1;

  logic [0:0]       r_state;
  logic [1:0]       r_phase;
  logic [CNT_W-1:0] r_count;
  logic [4:0]       r_x;
  logic             r_osop;
  logic             r_oval;
  logic             r_oeop;
  logic             r_oerr;
  logic [4:0]       r_odat0;
  logic [4:0]       r_odat1;

  logic             w_acc;
  logic [1:0]       w_phase;
  logic [CNT_W-1:0] w_count;
  logic             w_last;
  logic             w_beat;
  logic             w_end;
  logic             w_err;
  logic [4:0]       w_d0;
  logic [4:0]       w_d1;

  // Decide whether this symbol is taken, where it sits in the block
  // (an isop always restarts at phase 0, count 0), and what it produces.
  always_comb begin
    w_acc   = bus.ival & (bus.isop | (r_state == ST_RUN));
    w_phase = bus.isop ? 2'd0 : r_phase;
    w_count = bus.isop ? '0 : r_count;
    w_last  = (w_count == LAST_CNT);
    w_beat  = w_acc & (w_phase != 2'd0);
    w_end   = w_acc & (bus.ieop | w_last);
    w_err   = w_acc & ((bus.isop & (r_state == ST_RUN)) | (bus.ieop ^ w_last));
    w_d0    = r_odat0;
    w_d1    = r_odat1;
    case (w_phase)
      2'd1: begin w_d0 = r_x;       w_d1 = bus.idat;  end
      2'd2: begin w_d0 = ERASE_VAL; w_d1 = bus.idat;  end
      2'd3: begin w_d0 = bus.idat;  w_d1 = ERASE_VAL; end
      default: ;
    endcase
  end

  // Block tracking: state, phase, symbol count and the held X1 symbol.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_state <= ST_IDLE;
      r_phase <= 2'd0;
      r_count <= '0;
      r_x     <= 5'd0;
    end else if (w_acc) begin
      if (w_end) begin
        r_state <= ST_IDLE;
        r_phase <= 2'd0;
        r_count <= '0;
      end else begin
        r_state <= ST_RUN;
        r_phase <= w_phase + 2'd1;
        r_count <= w_count + ONE_CNT;
      end
      if (w_phase == 2'd0) begin
        r_x <= bus.idat;
      end
    end
  end

  // Registered output beat; data holds its last value between beats.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_oval  <= 1'b0;
      r_osop  <= 1'b0;
      r_oeop  <= 1'b0;
      r_oerr  <= 1'b0;
      r_odat0 <= 5'd0;
      r_odat1 <= 5'd0;
    end else begin
      r_oval <= w_beat;
      r_osop <= w_beat & (w_count == ONE_CNT);
      r_oeop <= w_beat & w_last;
      r_oerr <= w_err;
      if (w_beat) begin
        r_odat0 <= w_d0;
        r_odat1 <= w_d1;
      end
    end
  end

  assign bus.osop  = r_osop;
  assign bus.oval  = r_oval;
  assign bus.oeop  = r_oeop;
  assign bus.oerr  = r_oerr;
  assign bus.odat0 = r_odat0;
  assign bus.odat1 = r_odat1;

endmodule

// File: doc/soft_depuncture.md
SOFT_DEPUNCTURE -- requirements
Module: soft_depuncture

Interface
REQ-001 Parameter BLK_LEN, default 1920, soft symbols per code block (multiple of 4).
REQ-002 Parameter ERASE_VAL, default 5'd0, soft value inserted at punctured positions (zero LLR).
REQ-003 iclk  in  1  single clock; all logic on rising edge.
REQ-004 irst  in  1  asynchronous active-low reset.
REQ-005 isop  in  1  first symbol of code block, qualified by ival.
REQ-006 ival  in  1  input symbol valid; may drop any cycle, including mid-block.
REQ-007 ieop  in  1  last symbol of code block, qualified by ival.
REQ-008 idat  in  5  soft symbol from the de-interleaver.
REQ-009 osop  out 1  first output beat of block.
REQ-010 oval  out 1  output beat valid.
REQ-011 oeop  out 1  last output beat of block.
REQ-012 odat0 out 5  soft value for encoder branch X (G1).
REQ-013 odat1 out 5  soft value for encoder branch Y (G2).
REQ-014 oerr  out 1  one-cycle pulse on block-framing error.

Function
REQ-015 Rate-3/4 puncture pattern X=101, Y=110; received symbol order per group: X1 Y1 Y2 X3.
REQ-016 2-bit phase counter advances on each accepted symbol (ival & in-block), wraps 3->0.
REQ-017 Phase 0: store X1, no output; phase 1: emit (X1, Y1); phase 2: emit (ERASE_VAL, Y2); phase 3: emit (X3, ERASE_VAL).
REQ-018 Output registered; latency exactly 1 cycle from the accepted symbol completing a beat to oval.
REQ-019 3 beats per 4 symbols, no backpressure; BLK_LEN=1920 yields 1440 beats.
REQ-020 States: IDLE, RUN. IDLE->RUN on ival&isop (that symbol taken as phase 0, count 0).
REQ-021 In IDLE, ival without isop is discarded; no output, no error.
REQ-022 Symbol counter (11 bits for default, $clog2(BLK_LEN) generally) counts accepted symbols in RUN.
REQ-023 osop asserted with first beat of block only; oeop with beat produced by symbol count BLK_LEN-1.
REQ-024 Normal end: ival&ieop at count BLK_LEN-1 and phase 3 -> beat with oeop, RUN->IDLE.
REQ-025 Short block: ival&ieop with count != BLK_LEN-1 -> oerr pulse, beat for that symbol still emitted if phase 1-3 (without oeop), pending phase-0 X discarded, ->IDLE.
REQ-026 Long block: count reaches BLK_LEN-1 without ieop -> oeop on that beat, oerr pulse same cycle, ->IDLE; following symbols discarded until next isop.
REQ-027 isop while RUN (ival): oerr pulse, current block abandoned without oeop, symbol restarts new block at phase 0, count 0.
REQ-028 isop and ieop on same symbol: treated as isop (REQ-027/REQ-020) then short-block rule -> oerr, ->IDLE.
REQ-029 ival low: state, phase, count, stored X held; oval=0.
REQ-030 odat0/odat1 hold last value when oval=0; osop, oeop, oerr are 0 when not asserted.

Reset
REQ-031 irst low: state IDLE, phase 0, count 0, stored X 0, osop=oval=oeop=oerr=0, odat0=odat1=0, immediately (async).
REQ-032 irst deasserted mid-block: block lost; next beat only after new isop.

Verification
REQ-033 Block of 1920 symbols, idat=k mod 32, continuous ival -> 1440 beats, first (0,1) with osop, second (ERASE_VAL,2), third (3,ERASE_VAL), last with oeop, oerr never 1.
REQ-034 Same block with ival toggling 1/0 randomly -> identical beat sequence, oval only 1 cycle after phases 1-3.
REQ-035 ieop on symbol 1000 (phase 0) -> oerr pulse, no oeop, 750 beats total, IDLE after.
REQ-036 isop reasserted at symbol 500 -> oerr pulse, new block's first beat carries osop, 1440 beats follow.
REQ-037 2000 symbols without ieop -> oeop on beat 1440, oerr pulse same cycle, no beats for symbols 1920-1999.
REQ-038 irst low for 1 cycle at symbol 700 -> all outputs 0 immediately, no further beats until next isop.
